// File: rtl/encoder_sequential.sv
// Multi-hot to index stream: emits the index of every set bit of an accepted vector, lowest first.
// Latency 1 cycle accept->first beat, one beat per cycle; outputs hold while out_ready is low.
module encoder_sequential #(
  parameter  int N = 16,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_bits,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_index,
  output logic         out_last,
  output logic         done
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t       state;
  state_t       next_state;
  logic [N-1:0] pending;
  logic [N-1:0] pending_rest;
  logic         pending_onehot;
  logic         accept;
  logic         beat;

  // Clearing the lowest set bit also tells us whether exactly one bit remains.
  assign pending_rest   = pending & (pending - N'(1));
  assign pending_onehot = (pending != '0) && (pending_rest == '0);
  assign accept         = in_valid && in_ready;
  assign beat           = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (in_valid && (in_bits != '0)) next_state = EMIT;
      EMIT: if (out_ready && pending_onehot) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == EMIT);
    out_last  = (state == EMIT) && pending_onehot;
    out_index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending[i]) out_index = W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
      done    <= 1'b0;
    end else begin
      if (accept) begin
        pending <= in_bits;
      end else if (beat) begin
        pending <= pending_rest;
      end
      done <= (accept && (in_bits == '0)) || (beat && out_last);
    end
  end

endmodule

// File: tb/tb_encoder_sequential.sv
// Directed bench for encoder_sequential: cycle-by-cycle table plus a reset-mid-emit sequence.
module tb_encoder_sequential;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_bits;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_index;
  logic        out_last;
  logic        done;

  int applied;
  int miscompares;

  encoder_sequential #(.N(16)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_bits(in_bits),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_index(out_index),
    .out_last(out_last),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row = inputs held for a cycle and the outputs expected during that cycle.
  typedef struct {
    logic        iv;
    logic [15:0] bits;
    logic        ordy;
    logic        ov;
    logic        ir;
    logic        dn;
    logic [3:0]  idx;
    logic        last;
  } row_t;

  row_t tbl[$];

  task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic add(input logic iv, input logic [15:0] bits, input logic ordy,
                     input logic ov, input logic ir, input logic dn,
                     input logic [3:0] idx, input logic last);
    row_t r;
    r.iv = iv; r.bits = bits; r.ordy = ordy;
    r.ov = ov; r.ir = ir; r.dn = dn; r.idx = idx; r.last = last;
    tbl.push_back(r);
  endtask

  initial begin
    applied     = 0;
    miscompares = 0;

    //   iv  bits      ordy  ov ir dn idx last
    // single bit 0
    add(1, 16'h0001, 1,   0, 1, 0, 0, 0);
    add(0, 16'h0000, 1,   1, 0, 0, 0, 1);
    add(0, 16'h0000, 1,   0, 1, 1, 0, 0);
    add(0, 16'h0000, 1,   0, 1, 0, 0, 0);
    // 0x8421 -> 0,5,10,15
    add(1, 16'h8421, 1,   0, 1, 0, 0, 0);
    add(0, 16'h0000, 1,   1, 0, 0, 0, 0);
    add(0, 16'h0000, 1,   1, 0, 0, 5, 0);
    add(0, 16'h0000, 1,   1, 0, 0, 10, 0);
    add(0, 16'h0000, 1,   1, 0, 0, 15, 1);
    add(0, 16'h0000, 1,   0, 1, 1, 0, 0);
    // all-zero vector: done only
    add(1, 16'h0000, 1,   0, 1, 0, 0, 0);
    add(0, 16'h0000, 1,   0, 1, 1, 0, 0);
    add(0, 16'h0000, 1,   0, 1, 0, 0, 0);
    // 0x0006 with stall; in_valid with other bits during EMIT must be ignored
    add(1, 16'h0006, 0,   0, 1, 0, 0, 0);
    add(1, 16'hFFFF, 0,   1, 0, 0, 1, 0);
    add(0, 16'hFFFF, 0,   1, 0, 0, 1, 0);
    add(0, 16'h0000, 0,   1, 0, 0, 1, 0);
    add(0, 16'h0000, 1,   1, 0, 0, 1, 0);
    add(0, 16'h0000, 1,   1, 0, 0, 2, 1);
    add(0, 16'h0000, 1,   0, 1, 1, 0, 0);
    // back-to-back 0x0003 then 0x0010
    add(1, 16'h0003, 1,   0, 1, 0, 0, 0);
    add(0, 16'h0000, 1,   1, 0, 0, 0, 0);
    add(0, 16'h0000, 1,   1, 0, 0, 1, 1);
    add(1, 16'h0010, 1,   0, 1, 1, 0, 0);
    add(0, 16'h0000, 1,   1, 0, 0, 4, 1);
    add(0, 16'h0000, 1,   0, 1, 1, 0, 0);
    // top bit alone
    add(1, 16'h8000, 1,   0, 1, 0, 0, 0);
    add(0, 16'h0000, 1,   1, 0, 0, 15, 1);
    add(0, 16'h0000, 1,   0, 1, 1, 0, 0);
    add(0, 16'h0000, 1,   0, 1, 0, 0, 0);

    rst       = 1'b0;
    in_valid  = 1'b1;
    in_bits   = 16'h00FF;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_out_valid", -1, 32'(out_valid), 32'd0);
    check("rst_in_ready",  -1, 32'(in_ready),  32'd1);
    check("rst_done",      -1, 32'(done),      32'd0);
    check("rst_out_index", -1, 32'(out_index), 32'd0);
    check("rst_out_last",  -1, 32'(out_last),  32'd0);
    in_valid = 1'b0;
    rst      = 1'b1;

    foreach (tbl[r]) begin
      @(negedge clk);
      in_valid  = tbl[r].iv;
      in_bits   = tbl[r].bits;
      out_ready = tbl[r].ordy;
      #1;
      check("out_valid", r, 32'(out_valid), 32'(tbl[r].ov));
      check("in_ready",  r, 32'(in_ready),  32'(tbl[r].ir));
      check("done",      r, 32'(done),      32'(tbl[r].dn));
      if (tbl[r].ov) begin
        check("out_index", r, 32'(out_index), 32'(tbl[r].idx));
        check("out_last",  r, 32'(out_last),  32'(tbl[r].last));
      end
    end

    // 0xFFFF, reset asserted after the 4th beat is taken
    @(negedge clk);
    in_valid  = 1'b1;
    in_bits   = 16'hFFFF;
    out_ready = 1'b1;
    #1;
    check("ffff_accept_ready", 100, 32'(in_ready), 32'd1);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("ffff_valid", 101 + b, 32'(out_valid), 32'd1);
      check("ffff_index", 101 + b, 32'(out_index), 32'(b));
      check("ffff_last",  101 + b, 32'(out_last),  32'd0);
    end
    @(negedge clk);
    #1;
    check("ffff_pre_rst_index", 105, 32'(out_index), 32'd4);
    rst = 1'b0;
    #1;
    check("midrst_out_valid", 106, 32'(out_valid), 32'd0);
    check("midrst_in_ready",  106, 32'(in_ready),  32'd1);
    check("midrst_done",      106, 32'(done),      32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check("post_rst_out_valid", 107 + c, 32'(out_valid), 32'd0);
      check("post_rst_done",      107 + c, 32'(done),      32'd0);
      check("post_rst_in_ready",  107 + c, 32'(in_ready),  32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
